// File: rtl/life_board_ctrl.sv
// Game of Life board sequencer: registered board, per-cell next-state logic,
// row loader with valid/ready, single-step and free-running timed updates.

module cell8 (
  input  logic       alive,
  input  logic [7:0] nbrs,
  output logic       next_alive
);
  logic [3:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + 4'(nbrs[i]);
    next_alive = (cnt == 4'd3) || (alive && (cnt == 4'd2));
  end
endmodule

module life_board_ctrl #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned GEN_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   cmd_load,
  input  logic                   load_row_valid,
  output logic                   load_row_ready,
  input  logic [COLS-1:0]        load_row_data,
  input  logic                   step,
  input  logic                   run_en,
  input  logic [PERIOD_W-1:0]    period,
  output logic [ROWS*COLS-1:0]   cells,
  output logic [GEN_W-1:0]       generation,
  output logic                   running,
  output logic                   stable,
  output logic                   update_strobe
);
  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                state;
  logic [IDX_W-1:0]      row_idx;
  logic [PERIOD_W-1:0]   timer;
  logic                  step_req;
  logic [N-1:0]          next_cells;
  logic [ROWS+1:0][COLS+1:0] pad;
  logic [PERIOD_W-1:0]   period_last_c;
  logic                  do_update_c;

  // Board surrounded by a ring of dead cells so edge cells see zeros outside.
  always_comb begin
    pad = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pad[r+1][c+1] = cells[r*COLS+c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      cell8 u_cell (
        .alive      (pad[r+1][c+1]),
        .nbrs       ({pad[r][c],   pad[r][c+1],   pad[r][c+2],
                      pad[r+1][c],                pad[r+1][c+2],
                      pad[r+2][c], pad[r+2][c+1], pad[r+2][c+2]}),
        .next_alive (next_cells[r*COLS+c])
      );
    end
  end

  // A period of 0 behaves like 1: compare against 0 so every cycle fires.
  assign period_last_c = (period == '0) ? '0 : period - PERIOD_W'(1);

  assign do_update_c = !clear &&
                       (((state == IDLE) && step_req) ||
                        ((state == RUN) && run_en && (timer == period_last_c)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cells          <= '0;
      generation     <= '0;
      row_idx        <= '0;
      timer          <= '0;
      step_req       <= 1'b0;
      running        <= 1'b0;
      stable         <= 1'b0;
      update_strobe  <= 1'b0;
      load_row_ready <= 1'b0;
    end else if (clear) begin
      state          <= IDLE;
      cells          <= '0;
      generation     <= '0;
      row_idx        <= '0;
      timer          <= '0;
      step_req       <= 1'b0;
      running        <= 1'b0;
      stable         <= 1'b0;
      update_strobe  <= 1'b0;
      load_row_ready <= 1'b0;
    end else begin
      update_strobe <= do_update_c;
      step_req      <= 1'b0;
      if (do_update_c) begin
        cells      <= next_cells;
        generation <= generation + GEN_W'(1);
        stable     <= (next_cells == cells);
      end
      unique case (state)
        IDLE: begin
          if (cmd_load) begin
            state          <= LOAD;
            row_idx        <= '0;
            load_row_ready <= 1'b1;
          end else if (step) begin
            step_req <= 1'b1;
          end else if (run_en) begin
            state   <= RUN;
            timer   <= '0;
            running <= 1'b1;
          end
        end
        LOAD: begin
          if (load_row_valid) begin
            cells[32'(row_idx)*COLS +: COLS] <= load_row_data;
            if (row_idx == IDX_W'(ROWS - 1)) begin
              state          <= IDLE;
              generation     <= '0;
              stable         <= 1'b0;
              row_idx        <= '0;
              load_row_ready <= 1'b0;
            end else begin
              row_idx <= row_idx + IDX_W'(1);
            end
          end
        end
        RUN: begin
          if (!run_en) begin
            state   <= IDLE;
            timer   <= '0;
            running <= 1'b0;
          end else if (timer == period_last_c) begin
            timer <= '0;
          end else begin
            timer <= timer + PERIOD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_life_board_ctrl.sv
// Self-checking bench for life_board_ctrl: directed scenarios plus random
// boards, checked against a rule-level Game of Life model.

module tb_life_board_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        clear, cmd_load, load_row_valid, load_row_ready;
  logic [7:0]  load_row_data;
  logic        step, run_en;
  logic [23:0] period;
  logic [63:0] cells;
  logic [15:0] generation;
  logic        running, stable, update_strobe;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] mb;
  logic [15:0] mgen;
  logic        mstable;

  always #5 clk = ~clk;

  life_board_ctrl #(.ROWS(8), .COLS(8), .PERIOD_W(24), .GEN_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .cmd_load(cmd_load),
    .load_row_valid(load_row_valid), .load_row_ready(load_row_ready),
    .load_row_data(load_row_data), .step(step), .run_en(run_en),
    .period(period), .cells(cells), .generation(generation),
    .running(running), .stable(stable), .update_strobe(update_strobe)
  );

  function automatic logic [63:0] life(input logic [63:0] b);
    logic [63:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              cnt += int'(b[rr*8+cc]);
          end
        n[r*8+c] = (cnt == 3) || (b[r*8+c] && cnt == 2);
      end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_update();
    logic [63:0] nb;
    nb = life(mb);
    mstable = (nb == mb);
    mb = nb;
    mgen = mgen + 16'd1;
  endtask

  task automatic load_board(input logic [63:0] b, input int gap_row);
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    chk("load_ready_enter", 64'(load_row_ready), 64'd1);
    for (int r = 0; r < 8; r++) begin
      if (r == gap_row) begin
        load_row_valid = 1'b0;
        tick();
        tick();
        chk("load_ready_gap", 64'(load_row_ready), 64'd1);
      end
      load_row_valid = 1'b1;
      load_row_data  = b[r*8 +: 8];
      tick();
    end
    load_row_valid = 1'b0;
    mb = b;
    mgen = '0;
    mstable = 1'b0;
    chk("load_cells", cells, mb);
    chk("load_gen", 64'(generation), 64'd0);
    chk("load_ready_exit", 64'(load_row_ready), 64'd0);
    chk("load_stable", 64'(stable), 64'd0);
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_no_early_strobe", 64'(update_strobe), 64'd0);
    chk("step_no_early_cells", cells, mb);
    tick();
    model_update();
    chk("step_strobe", 64'(update_strobe), 64'd1);
    chk("step_cells", cells, mb);
    chk("step_gen", 64'(generation), 64'(mgen));
    chk("step_stable", 64'(stable), 64'(mstable));
    tick();
    chk("step_strobe_drop", 64'(update_strobe), 64'd0);
  endtask

  // Enter RUN, stay k cycles, then drop run_en; updates every max(p,1) cycles.
  task automatic run_seq(input int p, input int k);
    int pe;
    pe = (p == 0) ? 1 : p;
    period = 24'(p);
    run_en = 1'b1;
    tick();
    chk("run_enter", 64'(running), 64'd1);
    chk("run_enter_strobe", 64'(update_strobe), 64'd0);
    for (int i = 1; i <= k; i++) begin
      tick();
      if (i % pe == 0) model_update();
      chk("run_strobe", 64'(update_strobe), 64'((i % pe) == 0));
      chk("run_cells", cells, mb);
    end
    run_en = 1'b0;
    tick();
    chk("run_exit_strobe", 64'(update_strobe), 64'd0);
    chk("run_exit_running", 64'(running), 64'd0);
    chk("run_exit_cells", cells, mb);
    chk("run_exit_gen", 64'(generation), 64'(mgen));
    chk("run_exit_stable", 64'(stable), 64'(mstable));
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; cmd_load = 1'b0; load_row_valid = 1'b0;
    load_row_data = '0; step = 1'b0; run_en = 1'b0; period = '0;
    mb = '0; mgen = '0; mstable = 1'b0;
    #2;
    chk("reset_cells", cells, 64'd0);
    chk("reset_gen", 64'(generation), 64'd0);
    chk("reset_flags", 64'({running, stable, update_strobe, load_row_ready}), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Blinker, with a two-cycle valid gap between rows 3 and 4.
    load_board(64'h0000_0008_0808_0000, 4);
    do_step();
    chk("blinker_horizontal", cells, 64'h0000_0000_1C00_0000);
    chk("blinker_gen1", 64'(generation), 64'd1);
    chk("blinker_stable0", 64'(stable), 64'd0);
    do_step();
    chk("blinker_restored", cells, 64'h0000_0008_0808_0000);
    chk("blinker_gen2", 64'(generation), 64'd2);

    // Corner block still life.
    load_board(64'h0000_0000_0000_0303, -1);
    do_step();
    chk("block_unchanged", cells, 64'h0000_0000_0000_0303);
    chk("block_stable", 64'(stable), 64'd1);
    chk("block_gen", 64'(generation), 64'd1);

    // Timed run: period 3 with exit just before the 4th compare, then period 0.
    load_board(64'h0000_0008_0808_0000, -1);
    run_seq(3, 11);
    chk("run_p3_gen", 64'(generation), 64'd3);
    run_seq(0, 5);
    chk("run_p0_gen", 64'(generation), 64'd8);

    // Lone corner cell dies, then the empty board is stable.
    load_board(64'h8000_0000_0000_0000, -1);
    do_step();
    chk("dieoff_cells", cells, 64'd0);
    chk("dieoff_stable0", 64'(stable), 64'd0);
    do_step();
    chk("dieoff_stable1", 64'(stable), 64'd1);

    // Clear lands on the edge where a RUN update would have fired.
    load_board(64'h0000_0008_0808_0000, -1);
    period = 24'd3;
    run_en = 1'b1;
    tick();
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    run_en = 1'b0;
    mb = '0; mgen = '0; mstable = 1'b0;
    chk("clear_cells", cells, 64'd0);
    chk("clear_gen", 64'(generation), 64'd0);
    chk("clear_flags", 64'({running, stable, update_strobe}), 64'd0);

    // Async reset in the middle of a load, then a fresh load from row 0.
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    for (int r = 0; r < 3; r++) begin
      load_row_valid = 1'b1;
      load_row_data  = 8'hA5;
      tick();
    end
    load_row_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("midload_reset_cells", cells, 64'd0);
    chk("midload_reset_flags", 64'({running, stable, update_strobe, load_row_ready}), 64'd0);
    chk("midload_reset_gen", 64'(generation), 64'd0);
    #2 rst = 1'b1;
    tick();
    load_board(64'h0102_0408_1020_4080, -1);

    // Random boards through load, steps and timed runs.
    for (int t = 0; t < 6; t++) begin
      load_board({$urandom, $urandom}, int'($urandom_range(0, 8)));
      for (int s = 0; s < int'($urandom_range(1, 3)); s++) do_step();
      run_seq(int'($urandom_range(0, 4)), int'($urandom_range(1, 9)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/life_board_ctrl.md
Name: life_board_ctrl

Overview:
Sequencer for a ROWS x COLS Game of Life board. Holds the board state in registers and instantiates one `cell8` per cell to compute the next generation combinationally. Supports row-by-row loading through a valid/ready handshake, single-step updates, and free-running updates at a programmable period. Reports the generation count and detects a stable board. Sits between the control/UI logic (buttons, host loader) and the display/readout.

Parameters:
ROWS, 8, board height in cells
COLS, 8, board width in cells
PERIOD_W, 24, width of the run-period register
GEN_W, 16, width of the generation counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
clear  input  1  synchronous: zero the board and counters, go to IDLE
cmd_load  input  1  start a board load (honoured in IDLE only)
load_row_valid  input  1  load_row_data holds a valid row
load_row_ready  output  1  block accepts a row this cycle
load_row_data  input  COLS  row contents; bit c is column c
step  input  1  request one generation update (honoured in IDLE only)
run_en  input  1  level: free-run updates while high
period  input  PERIOD_W  clocks per generation in RUN; 0 is treated as 1
cells  output  ROWS*COLS  board state; bit r*COLS+c is row r, column c
generation  output  GEN_W  generations computed since the last load or clear
running  output  1  high while in RUN
stable  output  1  the last update produced an unchanged board
update_strobe  output  1  one-cycle pulse in the cycle the new board appears on cells

Behaviour:
- Reset (rst low, async): cells=0, generation=0, state=IDLE, row index=0, timer=0; running, stable, update_strobe and load_row_ready are all 0.
- Next-board logic: each cell feeds its current state and its 8 neighbours into `cell8`. Neighbours outside the board read as dead (zero padding, no wrap). Every cell updates simultaneously from the same snapshot.
- An "update" means all of the following in one clock edge:
  - cells <= next board
  - generation <= generation+1, wrapping modulo 2^GEN_W
  - stable <= (next board == current board)
  - update_strobe = 1 for exactly that cycle
- States: IDLE, LOAD, RUN.
- Command priority: clear > cmd_load > step > run_en. clear acts in any state and also sets stable=0 and update_strobe=0.
- IDLE:
  - cmd_load -> LOAD with row index=0.
  - Otherwise, step -> one update; stay in IDLE.
  - Otherwise, run_en -> RUN with timer=0.
- LOAD:
  - load_row_ready=1 throughout.
  - On valid&&ready: row[row index] <= load_row_data and row index increments.
  - Acceptance of row ROWS-1 returns the block to IDLE, sets generation=0 and stable=0, and resets row index to 0.
  - step, run_en and cmd_load are ignored. Valid may gap between rows with no effect.
- RUN:
  - running=1.
  - The timer counts every cycle. When timer == max(period,1)-1, the block performs an update and sets timer=0.
  - With period<=1, an update occurs every cycle.
  - A period change takes effect on the next compare.
  - run_en low -> IDLE on the next edge, timer=0, and no update in that cycle.
  - step and cmd_load are ignored.
- Timing: step sampled at edge N gives cells updated at edge N+1. The request is registered, so latency is exactly one cycle, and only one update occurs per step cycle. A multi-cycle step level gives one update per cycle; a single-step pulse source is the caller's responsibility.
- stable holds its value until the next update, load completion, clear or reset.
- Reset mid-LOAD discards the partial load; the board reads 0.

Test Plan:
- Blinker: load a vertical 3-cell line at column 3, rows 2-4 (8x8); pulse step once. Required: horizontal line at row 3, columns 2-4; generation=1; update_strobe high for exactly 1 cycle; stable=0. Step again: original board restored, generation=2.
- Block still-life: load a 2x2 block at rows 0-1, columns 0-1 (corner, tests zero padding); step. Required: board unchanged, stable=1, generation=1.
- Load handshake: cmd_load, then 8 rows with valid deasserted for 2 cycles between rows 3 and 4. Required: load_row_ready=1 during LOAD; all rows land correctly; return to IDLE after the 8th accept; generation=0.
- Run timing: blinker loaded, period=3, run_en held for 10 cycles. Required: update_strobe every 3rd cycle, 3 updates total, generation=3. Deassert run_en one cycle before the 4th compare: no 4th update, running=0 on the next cycle. Repeat with period=0: an update every cycle.
- Edge die-off: single live cell at row 7, column 7; step. Required: cells=0, stable=0. Step again: cells=0, stable=1.
- Clear/reset mid-operation: clear asserted in RUN -> cells=0, generation=0, state IDLE on the next edge, no strobe. rst low during LOAD after 3 rows -> all outputs 0 immediately; a subsequent load starts at row 0.
